// File: rtl/ocp_slave_mem.sv
// OCP responder backed by a word-addressed scratchpad: posted writes at one per cycle,
// non-posted commands answered after a fixed latency with a single request in flight.
package Bus;
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WR   = 3'd1,
      RD   = 3'd2,
      RDEX = 3'd3,
      RDL  = 3'd4,
      WRNP = 3'd5,
      WRC  = 3'd6,
      BCST = 3'd7
   } Ocp_cmd;

   typedef enum logic [1:0] {
      NULL = 2'd0,
      DVA  = 2'd1,
      FAIL = 2'd2,
      ERR  = 2'd3
   } Ocp_resp;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction
endpackage

module ocp_slave_mem #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 256,
   parameter int RD_LATENCY = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  Bus::Ocp_cmd             MCmd,
   input  logic [ADDR_WIDTH-1:0]   MAddr,
   input  logic [DATA_WIDTH-1:0]   MData,
   input  logic [DATA_WIDTH/8-1:0] MByteEn,
   output logic                    SCmdAccept,
   output Bus::Ocp_resp            SResp,
   output logic [DATA_WIDTH-1:0]   SData,
   input  logic                    MRespAccept
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int OFF_W = Bus::clog2(BYTES);
   localparam int IDX_W = (Bus::clog2(DEPTH) > 0) ? Bus::clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [3:0] LAT_M1 = 4'(RD_LATENCY - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

   state_e                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   Bus::Ocp_resp            resp_q, resp_d;
   logic [DATA_WIDTH-1:0]   sdata_q, sdata_d;
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

   logic [ADDR_WIDTH-1:0]   word_idx;
   logic [IDX_W-1:0]        mem_idx;
   logic                    in_range;
   logic                    cmd_valid, cmd_posted, cmd_write, cmd_read;
   logic                    accept, write_en;
   logic [DATA_WIDTH-1:0]   rd_word;

   assign word_idx = MAddr >> OFF_W;
   assign mem_idx  = word_idx[IDX_W-1:0];
   assign in_range = {1'b0, word_idx} < DEPTH_W;

   // Unknown or undefined command codes fall through to the default and look like IDLE.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      cmd_valid  = 1'b0;
      cmd_posted = 1'b0;
      cmd_write  = 1'b0;
      cmd_read   = 1'b0;
      case (MCmd)
         Bus::WR:   begin cmd_valid = 1'b1; cmd_posted = 1'b1; cmd_write = 1'b1; end
         Bus::WRNP: begin cmd_valid = 1'b1; cmd_write = 1'b1; end
         Bus::RD:   begin cmd_valid = 1'b1; cmd_read = 1'b1; end
         Bus::RDEX, Bus::RDL, Bus::WRC, Bus::BCST: cmd_valid = 1'b1;
         default: ;
      endcase
   end

   assign SCmdAccept = reset && (state_q == ST_IDLE);
   assign accept     = SCmdAccept && cmd_valid;
   assign write_en   = accept && cmd_write && in_range;
   assign rd_word    = mem_q[mem_idx];

   // NOTE: the memory array has no reset; contents survive reset and need no reset fan-out.
   always_ff @(posedge clk) begin
      if (write_en) begin
         for (int b = 0; b < BYTES; b++) begin
            if (MByteEn[b]) mem_q[mem_idx][8*b +: 8] <= MData[8*b +: 8];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      resp_d  = resp_q;
      sdata_d = sdata_q;
      case (state_q)
         ST_IDLE: begin
            if (accept && !cmd_posted) begin
               cnt_d   = LAT_M1;
               state_d = (RD_LATENCY == 1) ? ST_RESP : ST_WAIT;
               resp_d  = Bus::ERR;
               sdata_d = '0;
               if (in_range && cmd_read) begin
                  resp_d  = Bus::DVA;
                  sdata_d = rd_word;
               end else if (in_range && cmd_write) begin
                  resp_d = Bus::DVA;
               end
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = ST_RESP;
         end
         ST_RESP: begin
            if (MRespAccept) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         resp_q  <= Bus::NULL;
         sdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         resp_q  <= resp_d;
         sdata_q <= sdata_d;
      end
   end

   // The captured response stays hidden until the latency has elapsed.
   assign SResp = (state_q == ST_RESP) ? resp_q : Bus::NULL;
   assign SData = (state_q == ST_RESP) ? sdata_q : '0;

endmodule

// File: tb/tb_ocp_slave_mem.sv
// Self-checking bench for ocp_slave_mem: directed scenarios plus randomized traffic
// checked against an array-based model of the memory and the response rules.
module tb_ocp_slave_mem;
   localparam int AW    = 12;
   localparam int DW    = 32;
   localparam int DEPTH = 256;
   localparam int LAT   = 3;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   Bus::Ocp_cmd     mcmd = Bus::IDLE;
   logic [AW-1:0]   maddr = '0;
   logic [DW-1:0]   mdata = '0;
   logic [3:0]      mbyteen = '0;
   logic            mrespaccept = 1'b0;
   logic            scmdaccept;
   Bus::Ocp_resp    sresp;
   logic [DW-1:0]   sdata;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] ref_mem [DEPTH];

   typedef struct {
      logic         acc;
      Bus::Ocp_resp r;
      logic [31:0]  d;
      int           lat;
      bit           stable;
      bit           busy_ok;
      Bus::Ocp_resp r_after;
      logic         acc_after;
   } obs_t;

   ocp_slave_mem #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RD_LATENCY(LAT)
   ) dut (
      .clk(clk), .reset(reset), .MCmd(mcmd), .MAddr(maddr), .MData(mdata),
      .MByteEn(mbyteen), .SCmdAccept(scmdaccept), .SResp(sresp), .SData(sdata),
      .MRespAccept(mrespaccept)
   );

   always #5 clk = ~clk;

   // Reference: applies a command to the model memory and returns the response it owes.
   task automatic model(input Bus::Ocp_cmd c, input logic [11:0] a, input logic [31:0] d,
                        input logic [3:0] be, output Bus::Ocp_resp r, output logic [31:0] rd);
      int idx;
      bit inr;
      idx = int'(a) / 4;
      inr = idx < DEPTH;
      r   = Bus::ERR;
      rd  = '0;
      if ((c == Bus::WR || c == Bus::WRNP) && inr)
         for (int b = 0; b < 4; b++) if (be[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
      if (c == Bus::RD && inr) begin r = Bus::DVA; rd = ref_mem[idx]; end
      if (c == Bus::WRNP && inr) r = Bus::DVA;
      if (c == Bus::WR) r = Bus::NULL;
   endtask

   task automatic issue(input Bus::Ocp_cmd c, input logic [11:0] a, input logic [31:0] d,
                        input logic [3:0] be, output logic acc);
      @(negedge clk);
      mcmd = c; maddr = a; mdata = d; mbyteen = be;
      acc = scmdaccept;
      @(posedge clk);
   endtask

   task automatic go_idle();
      @(negedge clk);
      mcmd = Bus::IDLE;
   endtask

   // Observes one response after an accept edge, holding it for 'hold' extra cycles before accepting.
   task automatic wait_resp(input int hold, inout obs_t o);
      o.lat = -1; o.stable = 1'b1; o.busy_ok = 1'b1;
      o.r = Bus::NULL; o.d = '0; o.r_after = Bus::NULL; o.acc_after = 1'b0;
      for (int j = 0; j < 40; j++) begin
         @(negedge clk);
         mcmd = Bus::IDLE;
         if (sresp !== Bus::NULL) begin o.lat = j + 1; break; end
         if (scmdaccept !== 1'b0) o.busy_ok = 1'b0;
      end
      if (o.lat < 0) return;
      o.r = sresp; o.d = sdata;
      if (scmdaccept !== 1'b0) o.busy_ok = 1'b0;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         if (sresp !== o.r || sdata !== o.d) o.stable = 1'b0;
         if (scmdaccept !== 1'b0) o.busy_ok = 1'b0;
      end
      mrespaccept = 1'b1;
      @(negedge clk);
      mrespaccept = 1'b0;
      o.r_after = sresp;
      o.acc_after = scmdaccept;
   endtask

   task automatic run_np(input Bus::Ocp_cmd c, input logic [11:0] a, input logic [31:0] d,
                         input logic [3:0] be, input int hold, output obs_t o);
      logic acc;
      issue(c, a, d, be, acc);
      o.acc = acc;
      wait_resp(hold, o);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (scmdaccept !== 1'b0) begin n_errors++; $display("FAIL reset_accept got %0b exp 0", scmdaccept); end
      n_checks++; if (sresp !== Bus::NULL) begin n_errors++; $display("FAIL reset_resp got %0d exp 0", sresp); end
      n_checks++; if (sdata !== 32'h0) begin n_errors++; $display("FAIL reset_data got %h exp 0", sdata); end
      reset = 1'b1;
      @(negedge clk);
      n_checks++; if (scmdaccept !== 1'b1) begin n_errors++; $display("FAIL post_reset_accept got %0b exp 1", scmdaccept); end
   endtask

   task automatic test_raw();
      logic acc;
      obs_t o;
      Bus::Ocp_resp er;
      logic [31:0] ed;
      issue(Bus::WR, 12'h010, 32'hDEADBEEF, 4'hF, acc);
      model(Bus::WR, 12'h010, 32'hDEADBEEF, 4'hF, er, ed);
      n_checks++; if (acc !== 1'b1) begin n_errors++; $display("FAIL raw_wr_accept got %0b exp 1", acc); end
      run_np(Bus::RD, 12'h010, 32'h0, 4'h0, 0, o);
      model(Bus::RD, 12'h010, 32'h0, 4'h0, er, ed);
      n_checks++; if (o.acc !== 1'b1) begin n_errors++; $display("FAIL raw_rd_accept got %0b exp 1", o.acc); end
      n_checks++; if (o.lat !== LAT) begin n_errors++; $display("FAIL raw_latency got %0d exp %0d", o.lat, LAT); end
      n_checks++; if (o.r !== Bus::DVA) begin n_errors++; $display("FAIL raw_resp got %0d exp %0d", o.r, Bus::DVA); end
      n_checks++; if (o.d !== 32'hDEADBEEF) begin n_errors++; $display("FAIL raw_data got %h exp deadbeef", o.d); end
      n_checks++; if (o.r_after !== Bus::NULL || o.acc_after !== 1'b1) begin
         n_errors++; $display("FAIL raw_release resp %0d accept %0b exp 0/1", o.r_after, o.acc_after); end
   endtask

   task automatic test_byte_enable();
      logic acc1, acc2;
      obs_t o;
      Bus::Ocp_resp er;
      logic [31:0] ed;
      issue(Bus::WR, 12'h020, 32'h11223344, 4'hF, acc1);
      model(Bus::WR, 12'h020, 32'h11223344, 4'hF, er, ed);
      issue(Bus::WR, 12'h020, 32'hAABBCCDD, 4'b0101, acc2);
      model(Bus::WR, 12'h020, 32'hAABBCCDD, 4'b0101, er, ed);
      n_checks++; if ({acc1, acc2} !== 2'b11) begin n_errors++; $display("FAIL be_b2b_accept got %b exp 11", {acc1, acc2}); end
      run_np(Bus::RD, 12'h020, 32'h0, 4'h0, 0, o);
      n_checks++; if (o.r !== Bus::DVA || o.d !== 32'h11BB33DD) begin
         n_errors++; $display("FAIL be_merge resp %0d data %h exp 1/11bb33dd", o.r, o.d); end
   endtask

   task automatic test_hold();
      obs_t o;
      run_np(Bus::RD, 12'h010, 32'h0, 4'h0, 5, o);
      n_checks++; if (o.lat !== LAT) begin n_errors++; $display("FAIL hold_latency got %0d exp %0d", o.lat, LAT); end
      n_checks++; if (o.stable !== 1'b1) begin n_errors++; $display("FAIL hold_stable got %0b exp 1", o.stable); end
      n_checks++; if (o.busy_ok !== 1'b1) begin n_errors++; $display("FAIL hold_accept_low got %0b exp 1", o.busy_ok); end
      n_checks++; if (o.r !== Bus::DVA || o.d !== 32'hDEADBEEF) begin
         n_errors++; $display("FAIL hold_value resp %0d data %h exp 1/deadbeef", o.r, o.d); end
      n_checks++; if (o.r_after !== Bus::NULL || o.acc_after !== 1'b1) begin
         n_errors++; $display("FAIL hold_release resp %0d accept %0b exp 0/1", o.r_after, o.acc_after); end
   endtask

   task automatic test_out_of_range();
      logic acc;
      obs_t o;
      Bus::Ocp_resp er;
      logic [31:0] ed;
      bit quiet;
      issue(Bus::WR, 12'h000, 32'h0BADF00D, 4'hF, acc);
      model(Bus::WR, 12'h000, 32'h0BADF00D, 4'hF, er, ed);
      run_np(Bus::RD, 12'h400, 32'h0, 4'h0, 0, o);
      n_checks++; if (o.r !== Bus::ERR || o.d !== 32'h0) begin
         n_errors++; $display("FAIL oor_rd resp %0d data %h exp 3/0", o.r, o.d); end
      issue(Bus::WR, 12'h400, 32'hFFFFFFFF, 4'hF, acc);
      go_idle();
      quiet = 1'b1;
      repeat (LAT + 2) begin
         @(negedge clk);
         if (sresp !== Bus::NULL || scmdaccept !== 1'b1) quiet = 1'b0;
      end
      n_checks++; if (quiet !== 1'b1) begin n_errors++; $display("FAIL oor_wr_no_resp got %0b exp 1", quiet); end
      run_np(Bus::RD, 12'h000, 32'h0, 4'h0, 0, o);
      n_checks++; if (o.d !== 32'h0BADF00D) begin n_errors++; $display("FAIL oor_wr_word0 got %h exp 0badf00d", o.d); end
      run_np(Bus::WRNP, 12'h7FC, 32'h12345678, 4'hF, 0, o);
      n_checks++; if (o.r !== Bus::ERR || o.d !== 32'h0) begin
         n_errors++; $display("FAIL oor_wrnp resp %0d data %h exp 3/0", o.r, o.d); end
   endtask

   task automatic test_illegal_cmds();
      obs_t o;
      Bus::Ocp_resp er;
      logic [31:0] ed;
      Bus::Ocp_cmd cmds [4] = '{Bus::RDEX, Bus::BCST, Bus::RDL, Bus::WRC};
      foreach (cmds[i]) begin
         run_np(cmds[i], 12'h010, 32'hCAFEF00D, 4'hF, 0, o);
         n_checks++; if (o.r !== Bus::ERR || o.d !== 32'h0 || o.lat !== LAT) begin
            n_errors++; $display("FAIL illegal_cmd%0d resp %0d data %h lat %0d exp 3/0/%0d", i, o.r, o.d, o.lat, LAT); end
      end
      run_np(Bus::WRNP, 12'h004, 32'h5A5A5A5A, 4'hF, 0, o);
      model(Bus::WRNP, 12'h004, 32'h5A5A5A5A, 4'hF, er, ed);
      n_checks++; if (o.r !== Bus::DVA || o.d !== 32'h0) begin
         n_errors++; $display("FAIL wrnp_resp resp %0d data %h exp 1/0", o.r, o.d); end
      run_np(Bus::RD, 12'h004, 32'h0, 4'h0, 0, o);
      n_checks++; if (o.d !== 32'h5A5A5A5A) begin n_errors++; $display("FAIL wrnp_readback got %h exp 5a5a5a5a", o.d); end
      run_np(Bus::RD, 12'h010, 32'h0, 4'h0, 0, o);
      n_checks++; if (o.d !== 32'hDEADBEEF) begin n_errors++; $display("FAIL illegal_no_effect got %h exp deadbeef", o.d); end
   endtask

   task automatic test_back_to_back();
      logic acc;
      bit all_acc;
      obs_t o;
      Bus::Ocp_resp er;
      logic [31:0] ed;
      logic [31:0] val;
      all_acc = 1'b1;
      for (int i = 0; i < 6; i++) begin
         val = $urandom;
         issue(Bus::WR, 12'(12'h100 + 4 * i), val, 4'hF, acc);
         model(Bus::WR, 12'(12'h100 + 4 * i), val, 4'hF, er, ed);
         if (acc !== 1'b1) all_acc = 1'b0;
      end
      n_checks++; if (all_acc !== 1'b1) begin n_errors++; $display("FAIL b2b_accept got %0b exp 1", all_acc); end
      for (int i = 0; i < 6; i++) begin
         run_np(Bus::RD, 12'(12'h100 + 4 * i), 32'h0, 4'h0, 0, o);
         model(Bus::RD, 12'(12'h100 + 4 * i), 32'h0, 4'h0, er, ed);
         n_checks++; if (o.d !== ed) begin n_errors++; $display("FAIL b2b_read%0d got %h exp %h", i, o.d, ed); end
      end
   endtask

   task automatic test_reset_in_resp();
      logic acc;
      bit seen, stale;
      issue(Bus::RD, 12'h010, 32'h0, 4'h0, acc);
      seen = 1'b0;
      for (int j = 0; j < 40; j++) begin
         @(negedge clk);
         mcmd = Bus::IDLE;
         if (sresp === Bus::DVA) begin seen = 1'b1; break; end
      end
      n_checks++; if (seen !== 1'b1) begin n_errors++; $display("FAIL rst_resp_seen got %0b exp 1", seen); end
      reset = 1'b0;
      @(negedge clk);
      n_checks++; if (sresp !== Bus::NULL || scmdaccept !== 1'b0) begin
         n_errors++; $display("FAIL rst_in_resp resp %0d accept %0b exp 0/0", sresp, scmdaccept); end
      reset = 1'b1;
      @(negedge clk);
      n_checks++; if (scmdaccept !== 1'b1) begin n_errors++; $display("FAIL rst_release_accept got %0b exp 1", scmdaccept); end
      stale = 1'b0;
      repeat (LAT + 4) begin
         @(negedge clk);
         if (sresp !== Bus::NULL) stale = 1'b1;
      end
      n_checks++; if (stale !== 1'b0) begin n_errors++; $display("FAIL rst_stale_resp got %0b exp 0", stale); end
   endtask

   task automatic test_random();
      logic acc;
      obs_t o;
      Bus::Ocp_resp er;
      logic [31:0] ed, d;
      logic [11:0] a;
      logic [3:0] be;
      Bus::Ocp_cmd c;
      int sel;
      for (int w = 0; w < 8; w++) begin
         d = $urandom;
         issue(Bus::WR, 12'(12'h200 + 4 * w), d, 4'hF, acc);
         model(Bus::WR, 12'(12'h200 + 4 * w), d, 4'hF, er, ed);
      end
      for (int n = 0; n < 60; n++) begin
         sel = $urandom_range(0, 9);
         a   = 12'(12'h200 + 4 * $urandom_range(0, 7) + $urandom_range(0, 3));
         d   = $urandom;
         be  = 4'($urandom_range(0, 15));
         case (sel)
            0, 1, 2, 3: c = Bus::WR;
            4, 5, 6:    c = Bus::RD;
            7:          c = Bus::WRNP;
            8: begin
               c = ($urandom_range(0, 1) == 0) ? Bus::RD : Bus::WR;
               a = 12'h400 | 12'($urandom_range(0, 1023));
            end
            default: begin
               case ($urandom_range(0, 3))
                  0: c = Bus::RDEX;
                  1: c = Bus::RDL;
                  2: c = Bus::WRC;
                  default: c = Bus::BCST;
               endcase
            end
         endcase
         if (c == Bus::WR) begin
            issue(c, a, d, be, acc);
            model(c, a, d, be, er, ed);
            n_checks++; if (acc !== 1'b1) begin n_errors++; $display("FAIL rnd%0d_wr_accept got %0b exp 1", n, acc); end
         end else begin
            run_np(c, a, d, be, $urandom_range(0, 3), o);
            model(c, a, d, be, er, ed);
            n_checks++; if (o.r !== er || o.d !== ed || o.lat !== LAT) begin
               n_errors++; $display("FAIL rnd%0d cmd %0d addr %h resp %0d data %h lat %0d exp %0d/%h/%0d",
                                    n, c, a, o.r, o.d, o.lat, er, ed, LAT); end
            n_checks++; if (o.stable !== 1'b1 || o.busy_ok !== 1'b1 || o.r_after !== Bus::NULL || o.acc_after !== 1'b1) begin
               n_errors++; $display("FAIL rnd%0d_handshake stable %0b busy %0b after %0d/%0b exp 1/1/0/1",
                                    n, o.stable, o.busy_ok, o.r_after, o.acc_after); end
         end
      end
      go_idle();
      for (int w = 0; w < 8; w++) begin
         run_np(Bus::RD, 12'(12'h200 + 4 * w), 32'h0, 4'h0, 0, o);
         model(Bus::RD, 12'(12'h200 + 4 * w), 32'h0, 4'h0, er, ed);
         n_checks++; if (o.d !== ed) begin n_errors++; $display("FAIL rnd_final%0d got %h exp %h", w, o.d, ed); end
      end
   endtask

   initial begin
      test_reset();
      test_raw();
      test_byte_enable();
      test_hold();
      test_out_of_range();
      test_illegal_cmds();
      test_back_to_back();
      test_reset_in_resp();
      test_random();
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
